// File: rtl/pitch_pkg.sv
// Shared types and default configuration for the open-loop pitch scheduler.
package pitch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_START   = 3'd3,
    ST_RUN     = 3'd4,
    ST_CAPTURE = 3'd5
  } state_e;

  localparam int unsigned DEF_L_FRAME    = 80;
  localparam int unsigned DEF_PIT_MAX    = 143;
  localparam int unsigned DEF_PIT_MIN    = 20;
  localparam int unsigned DEF_ADDR_W     = 12;
  localparam int unsigned MAX_FRAME_SPAN = 32'd1 << DEF_ADDR_W;

  typedef struct packed {
    logic [15:0] l_frame;
    logic [15:0] pit_max;
    logic [15:0] pit_min;
  } cfg_t;

endpackage

// File: rtl/pitch_ol_loader.sv
// Sample loader: counts accepted samples and drives the scratch write port in the accept cycle.
module pitch_ol_loader
  import pitch_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              ready,
  input  logic              smp_valid,
  input  logic [15:0]       smp_data,
  input  logic [16:0]       span,
  output logic              wr_en_c,
  output logic [ADDR_W-1:0] wr_addr_c,
  output logic [31:0]       wr_data_c,
  output logic              last_wr_c
);

  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    wr_en_c   = smp_valid & ready;
    wr_addr_c = '0;
    wr_data_c = '0;
    cnt_d     = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (wr_en_c) begin
      cnt_d = cnt_q + ADDR_W'(1);
    end
    if (wr_en_c) begin
      wr_addr_c = cnt_q;
      wr_data_c = {{16{smp_data[15]}}, smp_data};
    end
    last_wr_c = wr_en_c && (17'(cnt_q) == (span - 17'd1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pitch_ol_sched.sv
// Open-loop pitch frame scheduler: validates config, loads samples, runs the pitch pipe, captures result.
// Optional RUN watchdog enabled by defining PITCH_OL_SCHED_TIMEOUT_EN.
module pitch_ol_sched
  import pitch_pkg::*;
#(
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic [15:0]       l_frame_in,
  input  logic [15:0]       pit_max_in,
  input  logic [15:0]       pit_min_in,
  input  logic              smp_valid,
  input  logic [15:0]       smp_data,
  output logic              smp_ready,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [31:0]       mem_wr_data,
  output logic              mem_owner,
  output logic              pipe_start,
  input  logic              pipe_done,
  input  logic [15:0]       pipe_p_max1,
  output logic [15:0]       pipe_l_frame,
  output logic [15:0]       pipe_pit_max,
  output logic [15:0]       pipe_pit_min,
  output logic [ADDR_W-1:0] pipe_signal,
  output logic              busy,
  output logic              result_valid,
  output logic [15:0]       p_max1,
  output logic              error
);

  localparam int unsigned MEM_DEPTH = 32'd1 << ADDR_W;

  state_e      state_q, state_d;
  cfg_t        cfg_q, cfg_d;
  logic [15:0] p_max1_q, p_max1_d;
  logic        error_q, error_d;
  logic        busy_q, busy_d;
  logic        ready_q, ready_d;
  logic        owner_q, owner_d;
  logic        pstart_q, pstart_d;
  logic        rvalid_q, rvalid_d;
  logic [16:0] span_c;
  logic        cfg_bad_c;
  logic        load_clr_c;
  logic        last_wr_c;
  logic        timeout_c;

  assign span_c    = 17'(cfg_q.l_frame) + 17'(cfg_q.pit_max);
  assign cfg_bad_c = (cfg_q.l_frame == 16'd0) || (cfg_q.pit_min > cfg_q.pit_max)
                  || (32'(span_c) > MEM_DEPTH);

`ifdef PITCH_OL_SCHED_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] run_cnt_q, run_cnt_d;

  // Counts RUN cycles; fires on the TIMEOUT_CYCLES-th RUN cycle.
  always_comb begin
    run_cnt_d = '0;
    if (state_q == ST_RUN) run_cnt_d = run_cnt_q + TO_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) run_cnt_q <= '0;
    else        run_cnt_q <= run_cnt_d;
  end

  assign timeout_c = (state_q == ST_RUN) && (run_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_c = 1'b0;
`endif

  pitch_ol_loader #(.ADDR_W(ADDR_W)) u_loader (
    .clk       (clk),
    .reset     (reset),
    .clr       (load_clr_c),
    .ready     (ready_q),
    .smp_valid (smp_valid),
    .smp_data  (smp_data),
    .span      (span_c),
    .wr_en_c   (mem_wr_en),
    .wr_addr_c (mem_wr_addr),
    .wr_data_c (mem_wr_data),
    .last_wr_c (last_wr_c)
  );

  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    error_d    = error_q;
    p_max1_d   = p_max1_q;
    load_clr_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          cfg_d.l_frame = l_frame_in;
          cfg_d.pit_max = pit_max_in;
          cfg_d.pit_min = pit_min_in;
          error_d       = 1'b0;
          state_d       = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (cfg_bad_c) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          load_clr_c = 1'b1;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD:  if (last_wr_c) state_d = ST_START;
      ST_START: state_d = ST_RUN;
      ST_RUN: begin
        if (pipe_done) begin
          state_d = ST_CAPTURE;
        end else if (timeout_c) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        p_max1_d = pipe_p_max1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Status strobes are registered copies of the state being entered.
    busy_d   = (state_d != ST_IDLE);
    ready_d  = (state_d == ST_LOAD);
    owner_d  = (state_d == ST_START) || (state_d == ST_RUN) || (state_d == ST_CAPTURE);
    pstart_d = (state_d == ST_START);
    rvalid_d = (state_q == ST_CAPTURE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cfg_q    <= '0;
      p_max1_q <= '0;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      owner_q  <= 1'b0;
      pstart_q <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cfg_q    <= cfg_d;
      p_max1_q <= p_max1_d;
      error_q  <= error_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      owner_q  <= owner_d;
      pstart_q <= pstart_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign smp_ready    = ready_q;
  assign mem_owner    = owner_q;
  assign pipe_start   = pstart_q;
  assign busy         = busy_q;
  assign result_valid = rvalid_q;
  assign p_max1       = p_max1_q;
  assign error        = error_q;
  assign pipe_l_frame = cfg_q.l_frame;
  assign pipe_pit_max = cfg_q.pit_max;
  assign pipe_pit_min = cfg_q.pit_min;
  assign pipe_signal  = ADDR_W'(cfg_q.pit_max);

endmodule

// File: tb/tb_pitch_ol_sched.sv
// Randomized self-checking bench for pitch_ol_sched with a transaction-level reference model.
module tb_pitch_ol_sched;
  import pitch_pkg::*;

  localparam int unsigned AW    = 12;
  localparam int unsigned DEPTH = 4096;

  logic          clk, reset, frame_start;
  logic [15:0]   l_frame_in, pit_max_in, pit_min_in;
  logic          smp_valid;
  logic [15:0]   smp_data;
  logic          smp_ready, mem_wr_en, mem_owner, pipe_start;
  logic [AW-1:0] mem_wr_addr, pipe_signal;
  logic [31:0]   mem_wr_data;
  logic          pipe_done;
  logic [15:0]   pipe_p_max1, pipe_l_frame, pipe_pit_max, pipe_pit_min, p_max1;
  logic          busy, result_valid, error;

  pitch_ol_sched #(.ADDR_W(AW), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .l_frame_in(l_frame_in), .pit_max_in(pit_max_in), .pit_min_in(pit_min_in),
    .smp_valid(smp_valid), .smp_data(smp_data), .smp_ready(smp_ready),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_owner(mem_owner), .pipe_start(pipe_start), .pipe_done(pipe_done),
    .pipe_p_max1(pipe_p_max1), .pipe_l_frame(pipe_l_frame), .pipe_pit_max(pipe_pit_max),
    .pipe_pit_min(pipe_pit_min), .pipe_signal(pipe_signal), .busy(busy),
    .result_valid(result_valid), .p_max1(p_max1), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: latched config, expected write stream and result.
  int          m_l, m_pm, m_pn, exp_span;
  logic [15:0] exp_p;
  logic [15:0] samples [DEPTH];
  int          wr_cnt, pstart_cnt, rv_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sext(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (mem_wr_en) begin
      chk("wr_addr", 32'(mem_wr_addr), 32'(wr_cnt));
      if (wr_cnt < DEPTH) chk("wr_data", mem_wr_data, sext(samples[wr_cnt]));
      chk("wr_owner", 32'(mem_owner), 32'd0);
      wr_cnt++;
    end
    if (busy) begin
      chk("cfg_l_frame", 32'(pipe_l_frame), 32'(m_l));
      chk("cfg_pit_max", 32'(pipe_pit_max), 32'(m_pm));
      chk("cfg_pit_min", 32'(pipe_pit_min), 32'(m_pn));
      chk("cfg_signal", 32'(pipe_signal), 32'(m_pm % DEPTH));
    end else begin
      chk("idle_outs", 32'({mem_owner, smp_ready, pipe_start, mem_wr_en}), 32'd0);
    end
    if (mem_owner) chk("owner_after_load", 32'(wr_cnt), 32'(exp_span));
    if (pipe_start) pstart_cnt++;
    if (result_valid) begin
      rv_cnt++;
      chk("rv_p_max1", 32'(p_max1), 32'(exp_p));
    end
  end

  // vmode: 0..100 = percent valid, 101 = strict 1/0 toggle.
  task automatic load_samples(input int n_stop, input int vmode, output bit ok);
    int idx = 0;
    int cyc = 0;
    while (idx < n_stop && cyc < 20000) begin
      if (vmode > 100) smp_valid = (cyc % 2 == 0);
      else             smp_valid = ($urandom_range(99) < vmode);
      smp_data = samples[idx];
      @(negedge clk);
      if (smp_valid && smp_ready) idx++;
      tick();
      cyc++;
    end
    smp_valid = 1'b0;
    ok = (idx == n_stop);
  endtask

  task automatic start_frame(input int l, input int pm, input int pn);
    m_l = l; m_pm = pm; m_pn = pn;
    exp_span = l + pm;
    wr_cnt = 0; pstart_cnt = 0; rv_cnt = 0;
    for (int i = 0; i < DEPTH; i++) samples[i] = 16'($urandom);
    l_frame_in = 16'(l); pit_max_in = 16'(pm); pit_min_in = 16'(pn);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    l_frame_in = 16'($urandom); pit_max_in = 16'($urandom); pit_min_in = 16'($urandom);
    chk("busy_check", 32'(busy), 32'd1);
    chk("err_cleared", 32'(error), 32'd0);
  endtask

  task automatic do_frame(input int l, input int pm, input int pn, input int vmode,
                          input bit poke, input logic [15:0] res);
    bit ok;
    bit legal;
    legal = (l != 0) && (pn <= pm) && (l + pm <= int'(DEPTH));
    start_frame(l, pm, pn);
    tick();
    if (!legal) begin
      chk("bad_error", 32'(error), 32'd1);
      chk("bad_busy", 32'(busy), 32'd0);
      chk("bad_writes", 32'(wr_cnt), 32'd0);
      tick();
      return;
    end
    chk("load_ready", 32'(smp_ready), 32'd1);
    load_samples(exp_span, vmode, ok);
    chk("load_done", 32'(ok), 32'd1);
    chk("pstart_lat", 32'(pipe_start), 32'd1);
    chk("owner_start", 32'(mem_owner), 32'd1);
    tick();
    chk("pstart_once", 32'(pipe_start), 32'd0);
    repeat ($urandom_range(1, 8)) tick();
    if (poke) begin
      frame_start = 1'b1; l_frame_in = 16'($urandom);
      tick();
      frame_start = 1'b0;
    end
    chk("run_busy", 32'(busy), 32'd1);
    exp_p = res; pipe_p_max1 = res; pipe_done = 1'b1;
    tick();
    pipe_done = 1'b0;
    chk("rv_early", 32'(result_valid), 32'd0);
    tick();
    chk("rv_lat", 32'(result_valid), 32'd1);
    chk("p_max1", 32'(p_max1), 32'(res));
    chk("idle_after", 32'(busy), 32'd0);
    pipe_p_max1 = 16'($urandom);
    tick();
    chk("rv_pulse", 32'(result_valid), 32'd0);
    chk("p_max1_hold", 32'(p_max1), 32'(res));
    chk("n_writes", 32'(wr_cnt), 32'(exp_span));
    chk("n_pstart", 32'(pstart_cnt), 32'd1);
    chk("n_rvalid", 32'(rv_cnt), 32'd1);
    chk("no_restart", 32'(busy), 32'd0);
  endtask

  initial begin
    bit ok;
    reset = 1'b0; frame_start = 1'b0; smp_valid = 1'b0; smp_data = '0;
    l_frame_in = '0; pit_max_in = '0; pit_min_in = '0;
    pipe_done = 1'b0; pipe_p_max1 = '0;
    m_l = 0; m_pm = 0; m_pn = 0; exp_span = 0; exp_p = '0;
    wr_cnt = 0; pstart_cnt = 0; rv_cnt = 0;
    repeat (3) tick();
    chk("rst_outs", 32'({busy, error, smp_ready, mem_owner, pipe_start, result_valid, mem_wr_en}), 32'd0);
    chk("rst_vals", 32'(p_max1) | 32'(pipe_l_frame) | 32'(pipe_pit_max) | 32'(pipe_pit_min), 32'd0);
    reset = 1'b1;
    tick();

    // Nominal frame with literal expectations.
    do_frame(DEF_L_FRAME, DEF_PIT_MAX, DEF_PIT_MIN, 100, 1'b0, 16'h0037);
    chk("nom_writes", 32'(wr_cnt), 32'd223);
    chk("nom_signal", 32'(pipe_signal), 32'd143);
    chk("nom_p_max1", 32'(p_max1), 32'h37);

    // pipe_done outside RUN is ignored.
    pipe_p_max1 = 16'hBEEF; pipe_done = 1'b1;
    tick();
    pipe_done = 1'b0;
    repeat (3) tick();
    chk("done_idle_rv", 32'(rv_cnt), 32'd1);
    chk("done_idle_p", 32'(p_max1), 32'h37);

    // Back-pressure toggle with a frame_start poked during RUN.
    do_frame(80, 143, 20, 101, 1'b1, 16'($urandom));

    // Illegal configurations and span boundaries.
    do_frame(80, 143, 150, 100, 1'b0, 16'h1);
    do_frame(0, 143, 20, 100, 1'b0, 16'h1);
    do_frame(3954, 143, 20, 100, 1'b0, 16'h1);
    do_frame(3953, 143, 143, 70, 1'b0, 16'hFFFF);
    do_frame(1, 0, 0, 100, 1'b0, 16'h8001);

    // Randomized legal frames.
    for (int f = 0; f < 4; f++) begin
      int l, pm, pn;
      l  = $urandom_range(1, 200);
      pm = $urandom_range(20, 300);
      pn = $urandom_range(0, pm);
      do_frame(l, pm, pn, $urandom_range(40, 100), f[0], 16'($urandom));
    end

    // Reset during LOAD aborts with everything cleared.
    start_frame(80, 143, 20);
    tick();
    load_samples(50, 80, ok);
    smp_valid = 1'b1;
    reset = 1'b0;
    #1;
    chk("abort_outs", 32'({busy, error, smp_ready, mem_owner, pipe_start, result_valid, mem_wr_en}), 32'd0);
    chk("abort_vals", 32'(p_max1) | 32'(pipe_l_frame) | 32'(pipe_pit_max) | 32'(mem_wr_addr) | mem_wr_data, 32'd0);
    m_l = 0; m_pm = 0; m_pn = 0;
    smp_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
    chk("abort_writes", 32'(wr_cnt), 32'd50);
    chk("abort_rv", 32'(rv_cnt), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);

    // RUN with no pipe_done.
    start_frame(20, 30, 10);
    tick();
    load_samples(exp_span, 100, ok);
    chk("to_pstart", 32'(pipe_start), 32'd1);
    tick();
`ifdef PITCH_OL_SCHED_TIMEOUT_EN
    repeat (99) tick();
    chk("to_busy_99", 32'(busy), 32'd1);
    chk("to_err_99", 32'(error), 32'd0);
    tick();
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_error", 32'(error), 32'd1);
    chk("to_rv", 32'(rv_cnt), 32'd0);
`else
    repeat (1000) tick();
    chk("no_to_busy", 32'(busy), 32'd1);
    chk("no_to_error", 32'(error), 32'd0);
    reset = 1'b0;
    #1;
    m_l = 0; m_pm = 0; m_pn = 0;
    chk("run_abort_busy", 32'(busy), 32'd0);
    tick();
    reset = 1'b1;
    tick();
`endif
    do_frame(DEF_L_FRAME, DEF_PIT_MAX, DEF_PIT_MIN, 90, 1'b0, 16'h0055);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pitch_ol_sched.md
PITCH_OL_SCHED -- requirements
Module: pitch_ol_sched

Interface
REQ-001 SHALL have parameter ADDR_W, default 12: scratch-memory address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535: maximum cycles in RUN; used only with the timeout feature.
REQ-003 SHALL have these ports, in this order:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low.
- frame_start  in  1  one-cycle request to process one frame.
- l_frame_in  in  16  frame length.
- pit_max_in  in  16  maximum lag.
- pit_min_in  in  16  minimum lag.
- smp_valid  in  1  sample-stream valid.
- smp_data  in  16  sample, two's complement.
- smp_ready  out  1  sample-stream ready.
- mem_wr_en  out  1  scratch write strobe.
- mem_wr_addr  out  ADDR_W  scratch write address.
- mem_wr_data  out  32  sign-extended sample.
- mem_owner  out  1  0 = scheduler drives scratch write port; 1 = pitch pipe drives it.
- pipe_start  out  1  start pulse to the pitch pipe.
- pipe_done  in  1  pitch pipe done.
- pipe_p_max1  in  16  pitch pipe result.
- pipe_l_frame, pipe_pit_max, pipe_pit_min  out  16  latched configuration.
- pipe_signal  out  ADDR_W  signal base pointer (= pit_max).
- busy  out  1  high in every state except IDLE.
- result_valid  out  1  one-cycle result strobe.
- p_max1  out  16  held result.
- error  out  1  sticky error flag; cleared by the next accepted frame_start.

Function
REQ-004 SHALL implement the states IDLE, CHECK, LOAD, START, RUN, CAPTURE.
REQ-005 IDLE: when frame_start=1, SHALL latch the three configuration inputs, clear error and go to CHECK. While busy=1, frame_start SHALL be ignored.
REQ-006 CHECK (1 cycle): SHALL set error and return to IDLE if any of these holds: l_frame=0; pit_min>pit_max; l_frame+pit_max > 2^ADDR_W (17-bit sum). Otherwise it SHALL clear the sample counter and go to LOAD.
REQ-007 LOAD:
- smp_ready=1.
- On each smp_valid&smp_ready cycle: mem_wr_en=1 in that same cycle, mem_wr_addr=counter, mem_wr_data=sign-extended smp_data; counter increments.
- After the write at counter = l_frame+pit_max-1, SHALL go to START.
- smp_valid=0 stalls LOAD indefinitely.
REQ-008 mem_owner SHALL be 0 in IDLE, CHECK and LOAD, and 1 in START, RUN and CAPTURE. mem_wr_en SHALL be 0 outside LOAD.
REQ-009 START: pipe_start=1 for exactly one cycle, then RUN.
REQ-010 RUN: SHALL wait for pipe_done=1 and then go to CAPTURE. pipe_done in any other state SHALL be ignored.
REQ-011 CAPTURE: SHALL register pipe_p_max1 into p_max1 and assert result_valid for one cycle in the next cycle (IDLE). p_max1 SHALL hold until the next capture.
REQ-012 Latency: from the last accepted sample to pipe_start is 1 cycle; from pipe_done to result_valid is 2 cycles.
REQ-013 The pipe_* configuration outputs SHALL stay stable from CHECK until the next accepted frame_start.

Reset
REQ-014 When reset=0, the block SHALL asynchronously go to IDLE, and mid-frame this SHALL abort with no result_valid. Reset values:
- all strobes, busy, error, smp_ready, mem_owner: 0.
- p_max1, pipe_*, mem_wr_addr, mem_wr_data: 0.

Configuration
REQ-015 With PITCH_OL_SCHED_TIMEOUT_EN defined:
- a RUN-cycle counter SHALL be present.
- If the counter reaches TIMEOUT_CYCLES without pipe_done, the block SHALL set error and go to IDLE with no result_valid.
REQ-016 Without PITCH_OL_SCHED_TIMEOUT_EN, no counter SHALL exist and RUN SHALL wait indefinitely.

Structure
REQ-017 The state enumeration, the default configuration constants (80/143/20) and the maximum frame span SHALL live in the shared package pitch_pkg.
REQ-018 A sub-module pitch_ol_loader (LOAD counter plus write-port drive) is natural; everything else SHALL stay in pitch_ol_sched.

Verification
REQ-019 The bench SHALL cover these scenarios:
- Nominal: l_frame=80, pit_max=143, pit_min=20; 223 samples → 223 writes at addresses 0..222; pipe_signal=143; one pipe_start; pipe_done with pipe_p_max1=0x0037 → p_max1=0x0037, result_valid 2 cycles after pipe_done.
- Back-pressure: smp_valid toggles 1/0 → still exactly 223 writes, contiguous addresses; mem_owner flips to 1 only after the last write.
- Illegal configuration: pit_min=150, pit_max=143 → error=1, busy=0 within 2 cycles, zero writes. l_frame=0 → same response.
- Busy rejection: frame_start during RUN is ignored; reset=0 during LOAD → IDLE, all outputs 0, no result_valid.
- Timeout (macro defined, TIMEOUT_CYCLES=100): no pipe_done → error=1 after 100 RUN cycles. Without the macro: still busy after 1000 cycles.
